// File: rtl/conv2d_pkg.sv
// Shared types and kernel-size constants for the conv2D compute stage.
package conv2d_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoadWt,
        StAccum,
        StOut
    } state_e;

    localparam int unsigned WT_DIM_DEF = 3;

    function automatic int unsigned wt_size(input int unsigned dim);
        return dim * dim;
    endfunction

    function automatic int unsigned half_wt_dim(input int unsigned dim);
        return dim / 2;
    endfunction

    localparam int unsigned WT_SIZE     = wt_size(WT_DIM_DEF);
    localparam int unsigned HALF_WT_DIM = half_wt_dim(WT_DIM_DEF);

endpackage

// File: rtl/conv2d_compute_if.sv
// Read-response and write-data streams between the memory interface (master)
// and the compute stage (slave).
interface conv2d_compute_if #(
    parameter int unsigned DWIDTH = 32
);
    logic [DWIDTH-1:0] rdata;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [DWIDTH-1:0] wdata;
    logic              wdata_valid;
    logic              wdata_ready;

    modport master (
        output rdata, rdata_valid, wdata_ready,
        input  rdata_ready, wdata, wdata_valid
    );

    modport slave (
        input  rdata, rdata_valid, wdata_ready,
        output rdata_ready, wdata, wdata_valid
    );
endinterface

// File: rtl/conv2d_mac.sv
// Multiply-accumulate with clear and enable; product and sum wrap modulo 2^DWIDTH.
module conv2d_mac #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DWIDTH-1:0] a_i,
    input  logic [DWIDTH-1:0] b_i,
    output logic [DWIDTH-1:0] acc_o
);
    logic [DWIDTH-1:0] acc_q, acc_d, prod;

    // Low DWIDTH bits of a product are identical for signed and unsigned operands.
    always_comb begin
        prod  = a_i * b_i;
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/conv2d_compute.sv
// conv2D compute stage: loads the kernel, then emits one OFM element per window.
// Define CONV2D_RELU_EN to clamp negative outputs to zero.
module conv2d_compute
    import conv2d_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned WT_DIM = WT_DIM_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] fm_dim_i,
    output logic        idle_o,
    conv2d_compute_if.slave bus
);
    localparam int unsigned WtSize = wt_size(WT_DIM);
    localparam int unsigned HalfWt = half_wt_dim(WT_DIM);
    localparam int unsigned CntW   = (WT_DIM > 1) ? $clog2(WT_DIM) : 1;
    localparam int unsigned IdxW   = (WtSize > 1) ? $clog2(WtSize) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WT_DIM - 1);

    state_e            state_q;
    logic [CntW-1:0]   m_q, n_q, m_step, n_step;
    logic [31:0]       x_q, y_q, fm_dim_q;
    logic [DWIDTH-1:0] wt_q [WtSize];
    logic [IdxW-1:0]   wt_idx;
    logic [31:0]       idx, idy;
    logic              halo, rd_fire, last_mn, mac_clr, mac_en;
    logic [DWIDTH-1:0] acc;

    always_comb begin
        wt_idx  = IdxW'(m_q) * IdxW'(WT_DIM) + IdxW'(n_q);
        // Two's-complement wrap makes bit 31 the "below zero" flag.
        idx     = x_q + 32'(n_q) - 32'(HalfWt);
        idy     = y_q + 32'(m_q) - 32'(HalfWt);
        halo    = idx[31] | idy[31] | (idx >= fm_dim_q) | (idy >= fm_dim_q);
        last_mn = (m_q == CntMax) && (n_q == CntMax);
        n_step  = (n_q == CntMax) ? '0 : n_q + 1'b1;
        m_step  = m_q;
        if (n_q == CntMax) begin
            m_step = (m_q == CntMax) ? '0 : m_q + 1'b1;
        end
        bus.rdata_ready = (state_q == StLoadWt) | ((state_q == StAccum) & ~halo);
        rd_fire = bus.rdata_valid & bus.rdata_ready;
        mac_en  = (state_q == StAccum) & rd_fire;
        mac_clr = ((state_q == StLoadWt) & rd_fire & last_mn)
                | ((state_q == StOut) & bus.wdata_ready);
    end

    conv2d_mac #(
        .DWIDTH(DWIDTH)
    ) u_mac (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(mac_clr),
        .en_i (mac_en),
        .a_i  (wt_q[wt_idx]),
        .b_i  (bus.rdata),
        .acc_o(acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            m_q      <= '0;
            n_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            fm_dim_q <= '0;
            wt_q     <= '{default: '0};
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q  <= StLoadWt;
                        fm_dim_q <= fm_dim_i;
                        m_q      <= '0;
                        n_q      <= '0;
                        x_q      <= '0;
                        y_q      <= '0;
                    end
                end
                StLoadWt: begin
                    if (rd_fire) begin
                        wt_q[wt_idx] <= bus.rdata;
                        m_q          <= m_step;
                        n_q          <= n_step;
                        if (last_mn) begin
                            state_q <= (fm_dim_q == '0) ? StIdle : StAccum;
                        end
                    end
                end
                StAccum: begin
                    // Halo cells step without a read beat.
                    if (halo || rd_fire) begin
                        m_q <= m_step;
                        n_q <= n_step;
                        if (last_mn) begin
                            state_q <= StOut;
                        end
                    end
                end
                StOut: begin
                    if (bus.wdata_ready) begin
                        state_q <= StAccum;
                        if (x_q == fm_dim_q - 32'd1) begin
                            x_q <= '0;
                            if (y_q == fm_dim_q - 32'd1) begin
                                state_q <= StIdle;
                            end else begin
                                y_q <= y_q + 32'd1;
                            end
                        end else begin
                            x_q <= x_q + 32'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign idle_o          = (state_q == StIdle);
    assign bus.wdata_valid = (state_q == StOut);
`ifdef CONV2D_RELU_EN
    assign bus.wdata = acc[DWIDTH-1] ? '0 : acc;
`else
    assign bus.wdata = acc;
`endif
endmodule

// File: tb/tb_conv2d_compute.sv
// Self-checking bench for conv2d_compute: directed table plus randomized runs
// checked against a window-level convolution model.
module tb_conv2d_compute;
    import conv2d_pkg::*;

    localparam int unsigned DW = 32;
    localparam int MaxFm = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] fm_dim = '0;
    logic        idle;

    conv2d_compute_if #(.DWIDTH(DW)) bus ();

    conv2d_compute #(
        .DWIDTH(DW),
        .WT_DIM(WT_DIM_DEF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .fm_dim_i(fm_dim),
        .idle_o  (idle),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [31:0] rq[$];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    int stamps[$];
    int vmode = 0;
    int wr_pct = 100;
    int hold_idx = -1;
    int hold_cnt = 0;
    logic [31:0] wts[WT_SIZE];
    logic [31:0] img[MaxFm*MaxFm];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, $signed(act), $signed(expv));
        end
    endtask

    // Read-response source: serves rq in order, gaps set by vmode.
    initial begin
        bit pend;
        bit tog;
        bit v;
        pend = 0;
        tog = 0;
        bus.rdata_valid = 1'b0;
        bus.rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0;
                bus.rdata_valid = 1'b0;
                continue;
            end
            if (pend && rq.size() > 0) void'(rq.pop_front());
            tog = ~tog;
            case (vmode)
                0:       v = 1'b1;
                1:       v = tog;
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.rdata_valid = v && (rq.size() > 0);
            bus.rdata = (rq.size() > 0) ? rq[0] : $urandom;
            pend = bus.rdata_valid && bus.rdata_ready;
        end
    end

    // Write-data sink with back-pressure and output-hold checks.
    initial begin
        bit hprev;
        bit wr;
        logic [31:0] pw;
        hprev = 0;
        pw = '0;
        bus.wdata_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hprev = 0;
                bus.wdata_ready = 1'b0;
                continue;
            end
            if (hprev) begin
                chk("valid_held", 32'(bus.wdata_valid), 32'd1);
                chk("wdata_held", bus.wdata, pw);
            end
            if (bus.wdata_valid) chk("rready_in_out", 32'(bus.rdata_ready), 32'd0);
            if (bus.wdata_valid && int'(got.size()) == hold_idx && hold_cnt < 5) begin
                wr = 0;
                hold_cnt++;
            end else begin
                wr = ($urandom_range(1, 100) <= wr_pct);
            end
            bus.wdata_ready = wr;
            if (bus.wdata_valid && wr) begin
                got.push_back(bus.wdata);
                stamps.push_back(cyc);
            end
            hprev = bus.wdata_valid && !wr;
            pw = bus.wdata;
        end
    end

    // Reference: full convolution with zero padding, plus the expected read-beat stream.
    task automatic build(input int fm);
        logic [31:0] acc;
        exp_q.delete();
        rq.delete();
        for (int i = 0; i < int'(WT_SIZE); i++) rq.push_back(wts[i]);
        for (int y = 0; y < fm; y++) begin
            for (int x = 0; x < fm; x++) begin
                acc = '0;
                for (int m = 0; m < int'(WT_DIM_DEF); m++) begin
                    for (int n = 0; n < int'(WT_DIM_DEF); n++) begin
                        int iy;
                        int ix;
                        iy = y - int'(HALF_WT_DIM) + m;
                        ix = x - int'(HALF_WT_DIM) + n;
                        if (iy >= 0 && iy < fm && ix >= 0 && ix < fm) begin
                            rq.push_back(img[iy*MaxFm+ix]);
                            acc = acc + wts[m*int'(WT_DIM_DEF)+n] * img[iy*MaxFm+ix];
                        end
                    end
                end
`ifdef CONV2D_RELU_EN
                if (acc[31]) acc = '0;
`endif
                exp_q.push_back(acc);
            end
        end
    endtask

    task automatic run_conv(input string nm, input int fm, input int vm, input int wp,
                            input int hidx, input bit lat);
        int budget;
        got.delete();
        stamps.delete();
        hold_cnt = 0;
        hold_idx = hidx;
        vmode = vm;
        wr_pct = wp;
        build(fm);
        @(negedge clk);
        start = 1'b1;
        fm_dim = 32'(fm);
        @(negedge clk);
        start = 1'b0;
        fm_dim = $urandom;
        chk({nm, "_busy"}, 32'(idle), 32'd0);
        budget = 0;
        while (!(idle && got.size() == exp_q.size() && rq.size() == 0) && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20000) chk({nm, "_timeout"}, 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        chk({nm, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        chk({nm, "_beats_left"}, 32'(rq.size()), 32'd0);
        chk({nm, "_idle"}, 32'(idle), 32'd1);
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_w%0d", nm, i), got[i], exp_q[i]);
        if (lat)
            for (int i = 1; i < stamps.size(); i++)
                chk($sformatf("%s_lat%0d", nm, i), 32'(stamps[i] - stamps[i-1]), WT_SIZE + 1);
    endtask

    task automatic fill(input int wc, input int ic);
        for (int i = 0; i < int'(WT_SIZE); i++) wts[i] = (wc == 0) ? 32'(i + 1) : 32'(wc);
        for (int i = 0; i < MaxFm * MaxFm; i++) img[i] = 32'(ic);
    endtask

    typedef struct {
        string nm;
        int    fm;
        int    wc;
        int    ic;
        int    vm;
        int    wp;
        int    hidx;
        bit    lat;
        int    nexp;
        int    expv[9];
    } vec_t;

    initial begin
        vec_t tbl[7];
        int fm;
        tbl[0] = '{"t1_fm1", 1, 0, 5, 0, 100, -1, 0, 1, '{25, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[1] = '{"t2_ones", 3, 1, 1, 0, 100, -1, 1, 9, '{4, 6, 4, 6, 9, 6, 4, 6, 4}};
        tbl[2] = '{"t3_hold", 3, 1, 1, 0, 100, 4, 0, 9, '{4, 6, 4, 6, 9, 6, 4, 6, 4}};
        tbl[3] = '{"t4_toggle", 3, 1, 1, 1, 100, -1, 0, 9, '{4, 6, 4, 6, 9, 6, 4, 6, 4}};
        tbl[4] = '{"t2_bp", 3, 1, 1, 2, 50, -1, 0, 9, '{4, 6, 4, 6, 9, 6, 4, 6, 4}};
`ifdef CONV2D_RELU_EN
        tbl[5] = '{"t5_neg", 3, -1, 2, 0, 100, -1, 0, 9, '{0, 0, 0, 0, 0, 0, 0, 0, 0}};
`else
        tbl[5] = '{"t5_neg", 3, -1, 2, 0, 100, -1, 0, 9,
                   '{-8, -12, -8, -12, -18, -12, -8, -12, -8}};
`endif
        tbl[6] = '{"fm0", 0, 0, 1, 0, 100, -1, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0}};

        repeat (3) @(negedge clk);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_rready", 32'(bus.rdata_ready), 32'd0);
        chk("rst_wvalid", 32'(bus.wdata_valid), 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        #2 rst_n = 1'b1;

        for (int t = 0; t < 7; t++) begin
            fill(tbl[t].wc, tbl[t].ic);
            run_conv(tbl[t].nm, tbl[t].fm, tbl[t].vm, tbl[t].wp, tbl[t].hidx, tbl[t].lat);
            for (int i = 0; i < tbl[t].nexp && i < got.size(); i++)
                chk($sformatf("%s_tbl%0d", tbl[t].nm, i), got[i], 32'(tbl[t].expv[i]));
            if (tbl[t].hidx >= 0) chk({tbl[t].nm, "_stalls"}, 32'(hold_cnt), 32'd5);
        end

        // Abort during the second window, then a clean rerun.
        fill(1, 1);
        got.delete();
        stamps.delete();
        hold_idx = -1;
        vmode = 0;
        wr_pct = 100;
        build(3);
        @(negedge clk);
        start = 1'b1;
        fm_dim = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && got.size() == 0; i++) @(negedge clk);
        chk("t6_first_out", 32'(got.size()), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_idle", 32'(idle), 32'd1);
        chk("t6_async_wvalid", 32'(bus.wdata_valid), 32'd0);
        chk("t6_async_rready", 32'(bus.rdata_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_no_out", 32'(got.size()), 32'd1);
        rq.delete();
        #2 rst_n = 1'b1;
        run_conv("t6_rerun", 3, 0, 100, -1, 1);

        for (int r = 0; r < 6; r++) begin
            fm = $urandom_range(1, 6);
            for (int i = 0; i < int'(WT_SIZE); i++)
                wts[i] = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 16)) - 8);
            for (int i = 0; i < MaxFm * MaxFm; i++)
                img[i] = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 16)) - 8);
            run_conv($sformatf("rnd%0d", r), fm, 2, $urandom_range(30, 100),
                     $urandom_range(0, 1) ? -1 : int'($urandom_range(0, fm * fm - 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
